muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read operands and returns a 32-bit result, tagged with its destination register, for writeback into the register file.
- Multi-cycle with a start/busy/done handshake; the hazard logic stalls the pipeline while busy=1.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- flush  in  1  synchronous abort of the in-flight operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (from register file RD1).
- op_b  in  XLEN  rs2 value (from register file RD2).
- rd_in  in  5  destination register address.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result and rd_out are valid while done=1.
- result  out  XLEN  registered result; holds its value until the next done.
- rd_out  out  5  destination address for writeback (register file AD3); WE3 = done.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=0, done=0, result=0, rd_out=0; counter and datapath registers cleared. Reset overrides start and flush, including mid-operation.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge T:
  - latch funct3 and rd_in;
  - convert signed operands to magnitudes and record the result sign;
  - counter=XLEN-1; busy=1;
  - next state CALC, or FIN directly for a special case.
- CALC: one iteration per cycle, 32 cycles (edges T+1..T+32).
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - Counter decrements each cycle; the cycle with counter=0 moves to FIN.
- FIN (edge T+33):
  - apply two's-complement sign fix and select the output word;
  - register result and rd_out; done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: normal ops give done in the cycle after edge T+33 (34 cycles after start). Special cases give done after edge T+1 (2 cycles).
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the product.
  - MULHSU: op_a signed, op_b unsigned.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops skip the sign fix.
- Special cases (short path):
  - Divide by zero: quotient = all ones; remainder = op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- start while busy=1 is ignored; the in-flight op is unaffected.
- start in the same cycle as done (state FIN) is ignored. A new op is accepted from the next cycle.
- flush=1 at an edge while busy: return to IDLE, busy=0; no done pulse; result and rd_out unchanged.
- flush=1 while IDLE: no effect, and start in the same cycle is dropped.
- flush and start together are never accepted.
- Operands are latched at start, so later changes on op_a/op_b/rd_in have no effect.
- done never asserts twice for one start.

Decomposition:
- Shared package riscv_pkg holds:
  - muldiv_op_t enum over funct3 values;
  - XLEN constant;
  - functions abs_val and neg_if for sign pre- and post-processing.
- One sub-module is natural: muldiv_core, the iterative datapath (product/remainder/quotient registers and the step adder). The FSM, handshake, special-case detection and sign fix stay in muldiv_unit.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> done exactly 34 cycles after start; result 0xFFFFFFEB; rd_out 5; busy high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU 42/0 -> 0xFFFFFFFF and REMU 42/0 -> 42, both with done 2 cycles after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; latency 2.
- Handshake:
  - second start at cycle 10 of an op -> ignored; one done only; original result.
  - flush at cycle 15 -> busy=0 next cycle; no done; result still the previous value.
  - new start afterwards completes normally.
- rst_n=0 at cycle 20 of a DIV -> next cycle busy=0, done=0, result=0, rd_out=0; no done pulse follows.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M multiply/divide types, width constant and sign helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN = 32;

    // funct3 encodings of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } muldiv_state_t;

    // Magnitude of an operand; unsigned operands pass through untouched.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? ((~v) + XLEN'(1)) : v;
    endfunction

    // Conditional two's-complement negation of a result word.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v,
                                               input logic            neg);
        return neg ? ((~v) + XLEN'(1)) : v;
    endfunction

    // Same, for the double-width product.
    function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v,
                                                      input logic              neg);
        return neg ? ((~v) + (2*XLEN)'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply / restoring divide, one bit per step.
// Latency: W steps after load; results visible in o_hi/o_lo after the last step.
// Backpressure: none; the controller sequences i_load/i_step.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_load          capture operand magnitudes and operation kind
//   i_step          perform one iteration
//   i_is_div        1 = divide, 0 = multiply (sampled on i_load)
//   i_a_mag/i_b_mag unsigned operand magnitudes
//   o_hi/o_lo       multiply: product high/low; divide: remainder/quotient
module muldiv_core
    import riscv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_is_div,
    input  logic [W-1:0] i_a_mag,
    input  logic [W-1:0] i_b_mag,
    output logic [W-1:0] o_hi,
    output logic [W-1:0] o_lo
);

    // r_acc: multiply -> {partial product, remaining multiplier bits}
    //        divide   -> {partial remainder, dividend bits / quotient bits}
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_m;        // multiplicand or divisor
    logic           r_div;

    logic [W:0]     w_add;
    logic [W:0]     w_shift;
    logic [W+1:0]   w_diff;
    logic           w_borrow;
    logic [W-1:0]   w_rem_nxt;
    logic [2*W-1:0] w_acc_nxt;
    logic           w_unused;

    always_comb begin
        w_add     = '0;
        w_shift   = '0;
        w_diff    = '0;
        w_borrow  = 1'b0;
        w_rem_nxt = '0;
        w_acc_nxt = r_acc;

        // Multiply: conditionally add multiplicand into the high half, then
        // shift the whole accumulator right, carry included.
        w_add = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_m} : {(W+1){1'b0}});

        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // The shifted remainder is below 2*divisor, so a successful subtract
        // always fits back into W bits.
        w_shift   = {r_acc[2*W-1:W], r_acc[W-1]};
        w_diff    = {1'b0, w_shift} - {2'b00, r_m};
        w_borrow  = w_diff[W+1];
        w_rem_nxt = w_borrow ? w_shift[W-1:0] : w_diff[W-1:0];

        if (r_div) begin
            w_acc_nxt = {w_rem_nxt, r_acc[W-2:0], ~w_borrow};
        end else begin
            w_acc_nxt = {w_add, r_acc[W-1:1]};
        end
    end

    // Bits that are provably zero whenever they would matter.
    assign w_unused = ^{w_diff[W], w_shift[W]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_m   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_div <= i_is_div;
            r_m   <= i_is_div ? i_b_mag : i_a_mag;
            r_acc <= {{W{1'b0}}, (i_is_div ? i_a_mag : i_b_mag)};
        end else if (i_step) begin
            r_acc <= w_acc_nxt;
        end
    end

    assign o_hi = r_acc[2*W-1:W];
    assign o_lo = r_acc[W-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with start/busy/done handshake and rd tagging.
// Latency: 34 cycles start->done (2 cycles for divide-by-zero / signed overflow).
// Backpressure: start ignored while busy and during the done cycle; flush aborts silently.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start, flush     request (sampled when idle) / abort of the in-flight op
//   funct3           M-extension operation select
//   op_a, op_b       rs1 / rs2 values, latched at start
//   rd_in            destination register, latched at start
//   busy, done       op in progress / one-cycle completion pulse (writeback enable)
//   result, rd_out   registered result and destination, held until next done
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t    r_state;
    muldiv_state_t    w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    muldiv_op_t       r_op;
    logic [4:0]       r_rd;
    logic             r_neg_main;   // sign of product / quotient
    logic             r_neg_rem;    // sign of remainder (follows dividend)
    logic             r_special;
    logic [XLEN-1:0]  r_spec_res;
    logic [XLEN-1:0]  r_result;
    logic [4:0]       r_rd_out;
    logic             r_done;

    muldiv_op_t       w_op;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special;
    logic [XLEN-1:0]  w_spec_res;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic             w_accept;
    logic             w_step;
    logic             w_finish;
    logic [XLEN-1:0]  w_hi;
    logic [XLEN-1:0]  w_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]  w_quot;
    logic [XLEN-1:0]  w_rem;
    logic [XLEN-1:0]  w_final;

    // ------------------------------------------------------------------
    // Operand decode: signedness, special cases, magnitudes
    // ------------------------------------------------------------------
    always_comb begin
        w_op       = muldiv_op_t'(funct3);
        // MUL treats both operands as unsigned: the low word is identical.
        w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

        w_div_zero = funct3[2] && (op_b == '0);
        w_overflow = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (op_a == MIN_NEG) && (op_b == '1);
        w_special  = w_div_zero || w_overflow;

        // funct3[1] distinguishes remainder from quotient within divides
        w_spec_res = '0;
        if (w_div_zero) begin
            w_spec_res = funct3[1] ? op_a : '1;
        end else if (w_overflow) begin
            w_spec_res = funct3[1] ? '0 : MIN_NEG;
        end

        w_a_mag = abs_val(op_a, w_a_signed);
        w_b_mag = abs_val(op_b, w_b_signed);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_done blocks a start coinciding with the completion pulse
                if (start && !flush && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_finish    = !flush;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    muldiv_core #(
        .W (XLEN)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (w_step),
        .i_is_div (funct3[2]),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_hi     (w_hi),
        .o_lo     (w_lo)
    );

    // Sign fix and output word selection
    always_comb begin
        w_prod  = neg_if_wide({w_hi, w_lo}, r_neg_main);
        w_quot  = neg_if(w_lo, r_neg_main);
        w_rem   = neg_if(w_hi, r_neg_rem);
        w_final = '0;
        if (r_special) begin
            w_final = r_spec_res;
        end else begin
            case (r_op)
                OP_MUL:                       w_final = w_prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU:              w_final = w_quot;
                default:                      w_final = w_rem;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= OP_MUL;
            r_rd       <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_rd_out   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_op       <= w_op;
                r_rd       <= rd_in;
                r_neg_main <= (w_a_signed & op_a[XLEN-1]) ^ (w_b_signed & op_b[XLEN-1]);
                r_neg_rem  <= w_a_signed & op_a[XLEN-1];
                r_special  <= w_special;
                r_spec_res <= w_spec_res;
                r_cnt      <= CNT_W'(XLEN-1);
            end else if (w_step) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_result <= w_final;
                r_rd_out <= r_rd;
            end
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops,
// all outputs compared every cycle against a behavioural model.
// Latency/backpressure behaviour is exercised through start/flush/reset stimulus.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_calc(input logic [2:0] f,
                                             input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] w;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            3'd0: begin w = {32'b0, a} * {32'b0, b}; return w[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); w = p; return w[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); w = p; return w[63:32]; end
            3'd3: begin w = {32'b0, a} * {32'b0, b}; return w[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_short(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) ||
               (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // ---------------- behavioural model ----------------
    // One op in flight, finishing at a known edge number; done is visible
    // in the cycle after that edge.
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_prev_done;
    int          edge_cnt = 0;
    int          m_finish_edge = 0;
    logic [31:0] m_pend_res = '0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_pend_rd = '0;
    logic [4:0]  m_rd = '0;
    bit          mon_en = 0;

    always @(posedge clk) begin
        edge_cnt++;
        m_prev_done = m_done;
        m_done      = 0;
        if (!rst_n) begin
            m_active = 0;
            m_res    = '0;
            m_rd     = '0;
        end else if (m_active) begin
            if (flush) begin
                m_active = 0;
            end else if (edge_cnt == m_finish_edge) begin
                m_active = 0;
                m_done   = 1;
                m_res    = m_pend_res;
                m_rd     = m_pend_rd;
            end
        end else if (start && !flush && !m_prev_done) begin
            m_active      = 1;
            m_pend_res    = ref_calc(funct3, op_a, op_b);
            m_pend_rd     = rd_in;
            m_finish_edge = edge_cnt + (is_short(funct3, op_a, op_b) ? 1 : 33);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy",   {31'b0, busy}, {31'b0, m_active});
            chk("done",   {31'b0, done}, {31'b0, m_done});
            chk("result", result, m_res);
            chk("rd_out", {27'b0, rd_out}, {27'b0, m_rd});
        end
    end

    // ---------------- stimulus helpers (all run on negedges) ----------------
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    // lat counts cycles from the start edge; returns on the done cycle
    task automatic wait_done(input int lat0, output int lat, output int nb);
        lat = lat0;
        nb  = 0;
        while (done !== 1'b1 && lat < 80) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic quiet(input int n, output int d);
        d = 0;
        repeat (n) begin
            @(negedge clk);
            if (done === 1'b1) d++;
        end
    endtask

    task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        int nb;
        issue(f, a, b, rd);
        wait_done(1, lat, nb);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_res"}, result, exp);
        chk({name, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_active || m_done) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", (k < 100) ? 32'd0 : 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int nb;
        int d;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL with full handshake timing
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(1, lat, nb);
        chk("mul_lat", lat, 34);
        chk("mul_busy_cycles", nb, 33);
        chk("mul_res", result, 32'hFFFF_FFEB);
        chk("mul_rd", {27'b0, rd_out}, 32'd5);
        @(negedge clk);

        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 34);
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
        run("divu",   3'b101, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 34);
        run("remu",   3'b111, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h0000_0001, 34);
        run("divu0",  3'b101, 32'd42, 32'd0, 5'd10, 32'hFFFF_FFFF, 2);
        run("remu0",  3'b111, 32'd42, 32'd0, 5'd11, 32'd42, 2);
        run("div0",   3'b100, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFF, 2);
        run("rem0",   3'b110, 32'hFFFF_FFFB, 32'd0, 5'd14, 32'hFFFF_FFFB, 2);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 2);

        // second start while busy is ignored
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9);
        repeat (9) @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd3; rd_in = 5'd20;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat, nb);
        chk("busystart_lat", lat, 34);
        chk("busystart_res", result, 32'hFFFF_FFEB);
        chk("busystart_rd", {27'b0, rd_out}, 32'd9);
        @(negedge clk);
        quiet(40, d);
        chk("busystart_extra_done", d, 0);

        // flush mid-operation
        issue(3'b100, 32'd1000, 32'd7, 5'd12);
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_res_hold", result, 32'hFFFF_FFEB);
        chk("flush_rd_hold", {27'b0, rd_out}, 32'd9);
        quiet(40, d);
        chk("flush_no_done", d, 0);
        run("post_flush_div", 3'b100, 32'd1000, 32'd7, 5'd12, 32'd142, 34);
        run("post_flush_rem", 3'b110, 32'd1000, 32'd7, 5'd17, 32'd6, 34);

        // start during the done cycle is dropped, next cycle accepted
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        wait_done(1, lat, nb);
        chk("donestart_first_res", result, 32'd14);
        start = 1'b1; funct3 = 3'b011; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; rd_in = 5'd4;
        @(negedge clk);
        chk("donestart_ignored", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        wait_done(1, lat, nb);
        chk("donestart_lat", lat, 34);
        chk("donestart_res", result, 32'hFFFF_FFFE);
        chk("donestart_rd", {27'b0, rd_out}, 32'd4);
        @(negedge clk);

        // flush and start together while idle: dropped
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idleflush_busy", {31'b0, busy}, 32'd0);
        quiet(5, d);
        chk("idleflush_no_done", d, 0);

        // reset mid-divide
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'b0, rd_out}, 32'd0);
        quiet(40, d);
        chk("rst_no_done", d, 0);

        // randomized traffic; the per-cycle compare does the checking
        for (int i = 0; i < 150; i++) begin
            int mode;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom));
            mode = $urandom_range(0, 7);
            if (mode == 0) begin
                repeat ($urandom_range(0, 36)) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end else if (mode == 1) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                start = 1'b1; funct3 = 3'($urandom); op_a = rand_opnd(); op_b = rand_opnd();
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
